wsum_acc: RTL and testbench
===========================

Name: wsum_acc

Overview:
- Accumulates a frame of N weighted samples produced by the upstream constant-coefficient multiplier stage (9-bit product bus).
- Presents the frame sum on a registered output with valid/ready handshake.
- Sits directly downstream of the multiplier, between it and the result writer.
- Frame length fixed by parameter; backpressure stalls the multiplier feed via o_in_ready.

Parameters:
- IN_W, 9, product width from upstream multiplier
- N, 8, samples per frame (2..256)
- OUT_W, 12, accumulator/output width (IN_W + clog2(N) for lossless; smaller allowed)

Ports:
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  synchronous active-low reset
- i_valid  input  1  upstream product valid
- i_w1  input  IN_W  upstream product (unsigned)
- o_in_ready  output  1  block accepts a sample this cycle
- i_clear  input  1  synchronous frame flush
- o_valid  output  1  o_sum holds a completed frame sum
- o_sum  output  OUT_W  frame sum (unsigned)
- i_out_ready  input  1  downstream accepts o_sum
- o_ovf  output  1  frame overflowed OUT_W (meaningful with the optional feature; 0 otherwise)

Behaviour:
- Single clock domain; reset is synchronous, active-low on i_rst_n, sampled on i_clk rising edge.
- Reset: state=IDLE, acc=0, cnt=0, o_valid=0, o_sum=0, o_ovf=0, o_in_ready=1.
- States: IDLE (cnt=0, acc=0), ACC (0<cnt<N), HOLD (result presented).
- o_in_ready = 1 in IDLE/ACC, 0 in HOLD. Accept = i_valid & o_in_ready.
- IDLE, accept: acc<=i_w1 (zero-extended), cnt<=1, ->ACC. If N reached on that accept (not possible for N>=2), see below.
- ACC, accept with cnt<N-1: acc<=acc+i_w1, cnt<=cnt+1.
- ACC, accept with cnt==N-1: o_sum<=acc+i_w1, o_valid<=1, acc<=0, cnt<=0, ->HOLD. Latency: o_valid high the cycle after the Nth accept.
- HOLD: o_sum, o_ovf stable until handshake. o_valid & i_out_ready -> o_valid<=0, ->IDLE; first new sample may be accepted the following cycle.
- i_valid low in ACC: hold acc/cnt; gaps of any length allowed.
- Arithmetic: unsigned, computed in OUT_W+1 bits; without feature, result truncated to OUT_W (wrap).
- i_clear (any state): acc<=0, cnt<=0, o_valid<=0, o_ovf<=0, ->IDLE. Clear beats a simultaneous accept (sample dropped) and a simultaneous output handshake (result discarded).
- Reset mid-frame: partial sum discarded, identical to reset values.

Optional Feature:
- Macro WSUM_SAT_EN.
- Defined: each addition saturates at 2^OUT_W-1; sticky per-frame overflow flag copied to o_ovf with o_sum; flag cleared on frame start, handshake, clear, reset.
- Undefined: modulo-2^OUT_W wrap; o_ovf tied 0.

Decomposition:
- Shared package wsum_pkg: state enum (IDLE/ACC/HOLD), default IN_W/N/OUT_W constants, CNT_W = clog2(N) localparam helper.
- One natural sub-module: wsum_ctrl (FSM + sample counter, emits o_in_ready, load/clear/commit strobes); datapath (adder, acc, output regs) in wsum_acc.

Test Plan:
- Reset, then 8 back-to-back samples of 51 with i_out_ready=1 -> o_valid one cycle after 8th accept, o_sum=408, o_ovf=0, back to IDLE.
- Samples 0,1,2..7 with i_valid gaps of 1-3 cycles -> o_sum=28; cnt/acc unchanged during gaps.
- Frame complete with i_out_ready=0 for 5 cycles while i_valid=1 -> o_in_ready=0, o_sum held at value, no sample consumed; after handshake next frame starts cleanly.
- 3 samples of 100 then i_clear asserted together with i_valid -> no output; next 8 samples of 10 -> o_sum=80.
- OUT_W=9, 8 samples of 511: without WSUM_SAT_EN -> o_sum=4088 mod 512=504, o_ovf=0; with WSUM_SAT_EN -> o_sum=511, o_ovf=1.
- i_rst_n low for 1 cycle after 5 accepts -> all outputs at reset values; next full frame of 7s -> o_sum=56.

Source files
------------

// File: rtl/wsum_pkg.sv
// Shared types and constants for the weighted-sample frame accumulator.
package wsum_pkg;

    localparam int unsigned IN_W_DEF  = 9;
    localparam int unsigned N_DEF     = 8;
    localparam int unsigned OUT_W_DEF = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wsum_ctrl.sv
// Frame FSM and sample counter; emits input ready plus load/add/commit/handshake strobes.
module wsum_ctrl
    import wsum_pkg::*;
#(
    parameter int unsigned N = N_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_valid,
    input  logic i_clear,
    input  logic i_out_ready,
    output logic o_in_ready,
    output logic o_load_c,
    output logic o_add_c,
    output logic o_commit_c,
    output logic o_hs_c
);

    localparam int unsigned CNT_W = cnt_w(N);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             in_ready_q;
    logic             accept_c;
    logic             last_c;

    // A clear wins over any simultaneous accept or output handshake.
    assign accept_c   = i_valid & in_ready_q & ~i_clear;
    assign last_c     = (cnt_q == CNT_W'(N - 1));
    assign o_load_c   = accept_c & (state_q == ST_IDLE);
    assign o_add_c    = accept_c & (state_q == ST_ACC) & ~last_c;
    assign o_commit_c = accept_c & (state_q == ST_ACC) & last_c;
    assign o_hs_c     = (state_q == ST_HOLD) & i_out_ready & ~i_clear;
    assign o_in_ready = in_ready_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (o_load_c) begin
                        cnt_q   <= CNT_W'(1);
                        state_q <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (o_commit_c) begin
                        cnt_q      <= '0;
                        state_q    <= ST_HOLD;
                        in_ready_q <= 1'b0;
                    end else if (o_add_c) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (o_hs_c) begin
                        state_q    <= ST_IDLE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    cnt_q      <= '0;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/wsum_acc.sv
// Frame accumulator datapath: sums N unsigned products and presents the total with valid/ready.
// Define WSUM_SAT_EN for saturating arithmetic and a per-frame overflow flag on o_ovf.
module wsum_acc
    import wsum_pkg::*;
#(
    parameter int unsigned IN_W  = IN_W_DEF,
    parameter int unsigned N     = N_DEF,
    parameter int unsigned OUT_W = OUT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [IN_W-1:0]  i_w1,
    output logic             o_in_ready,
    input  logic             i_clear,
    output logic             o_valid,
    output logic [OUT_W-1:0] o_sum,
    input  logic             i_out_ready,
    output logic             o_ovf
);

    logic             load_c;
    logic             add_c;
    logic             commit_c;
    logic             hs_c;
    logic [OUT_W-1:0] acc_q;
    logic [OUT_W-1:0] sum_q;
    logic             valid_q;
    logic [OUT_W-1:0] base_c;
    logic [OUT_W-1:0] nxt_c;

    wsum_ctrl #(.N(N)) u_ctrl (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .i_clear     (i_clear),
        .i_out_ready (i_out_ready),
        .o_in_ready  (o_in_ready),
        .o_load_c    (load_c),
        .o_add_c     (add_c),
        .o_commit_c  (commit_c),
        .o_hs_c      (hs_c)
    );

    // The first sample of a frame is added to zero rather than to the stale accumulator.
    assign base_c = load_c ? '0 : acc_q;

`ifdef WSUM_SAT_EN
    logic [OUT_W:0] sum_w;
    logic           ovf_c;
    logic           ovf_q;
    logic           ovf_out_q;

    assign sum_w = {1'b0, base_c} + (OUT_W + 1)'(i_w1);
    assign ovf_c = sum_w[OUT_W];
    assign nxt_c = ovf_c ? '1 : sum_w[OUT_W-1:0];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            ovf_q     <= 1'b0;
            ovf_out_q <= 1'b0;
        end else begin
            if (load_c) ovf_q <= ovf_c;
            if (add_c)  ovf_q <= ovf_q | ovf_c;
            if (commit_c) begin
                ovf_out_q <= ovf_q | ovf_c;
                ovf_q     <= 1'b0;
            end
            if (hs_c) ovf_out_q <= 1'b0;
        end
    end

    assign o_ovf = ovf_out_q;
`else
    assign nxt_c = base_c + OUT_W'(i_w1);
    assign o_ovf = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            acc_q   <= '0;
            sum_q   <= '0;
            valid_q <= 1'b0;
        end else if (i_clear) begin
            acc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            if (load_c || add_c) acc_q <= nxt_c;
            if (commit_c) begin
                acc_q   <= '0;
                sum_q   <= nxt_c;
                valid_q <= 1'b1;
            end
            if (hs_c) valid_q <= 1'b0;
        end
    end

    assign o_valid = valid_q;
    assign o_sum   = sum_q;

endmodule

// File: tb/tb_wsum_acc.sv
// Directed-vector bench for wsum_acc: default 12-bit instance plus a 9-bit instance for wrap/saturation.
module tb_wsum_acc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic [8:0]  i_w1;
    logic        i_clear;
    logic        i_out_ready;

    logic        in_ready;
    logic        valid;
    logic [11:0] sum;
    logic        ovf;

    logic        in_ready9;
    logic        valid9;
    logic [8:0]  sum9;
    logic        ovf9;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wsum_acc #(.IN_W(9), .N(8), .OUT_W(12)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_valid     (i_valid),
        .i_w1        (i_w1),
        .o_in_ready  (in_ready),
        .i_clear     (i_clear),
        .o_valid     (valid),
        .o_sum       (sum),
        .i_out_ready (i_out_ready),
        .o_ovf       (ovf)
    );

    wsum_acc #(.IN_W(9), .N(8), .OUT_W(9)) dut9 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_valid     (i_valid),
        .i_w1        (i_w1),
        .o_in_ready  (in_ready9),
        .i_clear     (i_clear),
        .o_valid     (valid9),
        .o_sum       (sum9),
        .i_out_ready (i_out_ready),
        .o_ovf       (ovf9)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [8:0] w);
        i_valid = 1'b1;
        i_w1    = w;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [8:0] w);
        for (int k = 0; k < 8; k++) send(w);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_valid = 1'b0; i_w1 = '0; i_clear = 1'b0; i_out_ready = 1'b1;
        tick(); tick();
        n_vec++;
        if ({valid, sum, ovf, in_ready} !== {1'b0, 12'd0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_state: got v=%0b s=%0d o=%0b r=%0b want v=0 s=0 o=0 r=1", valid, sum, ovf, in_ready);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        send_frame(9'd51);
        n_vec++;
        if ({valid, sum, ovf, in_ready} !== {1'b1, 12'd408, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL b2b_result: got v=%0b s=%0d o=%0b r=%0b want v=1 s=408 o=0 r=0", valid, sum, ovf, in_ready);
        end
        tick();
        n_vec++;
        if ({valid, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL b2b_idle: got v=%0b r=%0b want v=0 r=1", valid, in_ready);
        end
    endtask

    task automatic test_gaps();
        int exp_acc = 0;
        for (int i = 0; i < 7; i++) begin
            send(9'(i));
            exp_acc += i;
            for (int g = 0; g <= i % 3; g++) begin
                tick();
                n_vec++;
                if (dut.acc_q !== 12'(exp_acc) || valid !== 1'b0 || in_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL gap_hold: got acc=%0d v=%0b r=%0b want acc=%0d v=0 r=1", dut.acc_q, valid, in_ready, exp_acc);
                end
            end
        end
        send(9'd7);
        n_vec++;
        if ({valid, sum} !== {1'b1, 12'd28}) begin
            n_err++;
            $display("FAIL gap_result: got v=%0b s=%0d want v=1 s=28", valid, sum);
        end
        tick();
    endtask

    task automatic test_backpressure();
        i_out_ready = 1'b0;
        send_frame(9'd20);
        for (int c = 0; c < 5; c++) begin
            i_valid = 1'b1;
            i_w1    = 9'd99;
            tick();
            n_vec++;
            if ({in_ready, valid, sum} !== {1'b0, 1'b1, 12'd160}) begin
                n_err++;
                $display("FAIL bp_hold: got r=%0b v=%0b s=%0d want r=0 v=1 s=160", in_ready, valid, sum);
            end
        end
        i_valid     = 1'b0;
        i_out_ready = 1'b1;
        tick();
        n_vec++;
        if ({valid, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL bp_release: got v=%0b r=%0b want v=0 r=1", valid, in_ready);
        end
        send_frame(9'd5);
        n_vec++;
        if ({valid, sum} !== {1'b1, 12'd40}) begin
            n_err++;
            $display("FAIL bp_next_frame: got v=%0b s=%0d want v=1 s=40", valid, sum);
        end
        tick();
    endtask

    task automatic test_clear();
        for (int k = 0; k < 3; k++) send(9'd100);
        i_clear = 1'b1;
        i_valid = 1'b1;
        i_w1    = 9'd100;
        tick();
        i_clear = 1'b0;
        i_valid = 1'b0;
        n_vec++;
        if ({valid, in_ready} !== 2'b01 || dut.acc_q !== 12'd0) begin
            n_err++;
            $display("FAIL clear_flush: got v=%0b r=%0b acc=%0d want v=0 r=1 acc=0", valid, in_ready, dut.acc_q);
        end
        send_frame(9'd10);
        n_vec++;
        if ({valid, sum} !== {1'b1, 12'd80}) begin
            n_err++;
            $display("FAIL clear_next_frame: got v=%0b s=%0d want v=1 s=80", valid, sum);
        end
        tick();
        // Clear against a pending handshake discards the result.
        i_out_ready = 1'b0;
        send_frame(9'd3);
        i_clear     = 1'b1;
        i_out_ready = 1'b1;
        tick();
        i_clear = 1'b0;
        n_vec++;
        if ({valid, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL clear_vs_handshake: got v=%0b r=%0b want v=0 r=1", valid, in_ready);
        end
    endtask

    task automatic test_overflow();
        logic [8:0] exp_sum9;
        logic       exp_ovf9;
`ifdef WSUM_SAT_EN
        exp_sum9 = 9'd511;
        exp_ovf9 = 1'b1;
`else
        exp_sum9 = 9'd504;
        exp_ovf9 = 1'b0;
`endif
        send_frame(9'd511);
        n_vec++;
        if ({valid9, sum9, ovf9} !== {1'b1, exp_sum9, exp_ovf9}) begin
            n_err++;
            $display("FAIL ovf_narrow: got v=%0b s=%0d o=%0b want v=1 s=%0d o=%0b", valid9, sum9, ovf9, exp_sum9, exp_ovf9);
        end
        n_vec++;
        if ({valid, sum, ovf} !== {1'b1, 12'd4088, 1'b0}) begin
            n_err++;
            $display("FAIL ovf_wide: got v=%0b s=%0d o=%0b want v=1 s=4088 o=0", valid, sum, ovf);
        end
        tick();
        n_vec++;
        if ({valid9, ovf9} !== 2'b00) begin
            n_err++;
            $display("FAIL ovf_after_handshake: got v=%0b o=%0b want v=0 o=0", valid9, ovf9);
        end
    endtask

    task automatic test_mid_frame_reset();
        // Leave a completed 4088 in o_sum so the reset visibly clears it.
        i_out_ready = 1'b0;
        send_frame(9'd511);
        i_out_ready = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) send(9'd7);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_vec++;
        if ({valid, sum, ovf, in_ready} !== {1'b0, 12'd0, 1'b0, 1'b1} || dut.acc_q !== 12'd0) begin
            n_err++;
            $display("FAIL midframe_reset: got v=%0b s=%0d o=%0b r=%0b acc=%0d want v=0 s=0 o=0 r=1 acc=0",
                     valid, sum, ovf, in_ready, dut.acc_q);
        end
        send_frame(9'd7);
        n_vec++;
        if ({valid, sum} !== {1'b1, 12'd56}) begin
            n_err++;
            $display("FAIL reset_next_frame: got v=%0b s=%0d want v=1 s=56", valid, sum);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_backpressure();
        test_clear();
        test_overflow();
        test_mid_frame_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
